// File: rtl/mdu_pkg.sv
// Shared opcodes, cycle defaults and sequencer state for the MDU.
// Optional multiply-accumulate support is enabled by MDU_MADD_EN.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

  // Ops that occupy the unit for several cycles.
  function automatic logic is_long(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// State/counter sequencer for the MDU: IDLE/RUN with a down-counter.
// done_o marks the last busy cycle, when results are committed.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept_i,
  input  logic [CW-1:0] load_i,
  output logic          busy_o,
  output logic          done_o
);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy_o = (state_q == S_RUN);
  assign done_o = busy_o && (cnt_q <= CW'(1));

  // Next state: load on accept, count down, leave RUN at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_i) begin
          state_d = S_RUN;
          cnt_d   = load_i;
        end
      end
      S_RUN: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to enable madd/msub accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        illegal_issue
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          accept;
  logic          done;
  logic [CW-1:0] load;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        ill_q, ill_d;

  logic [63:0] prod_s, prod_u;
  logic        sgn;
  logic [31:0] abs_a, abs_b, b_nz;
  logic [31:0] q_u, r_u, q_s, r_s;

  assign accept    = start && !busy && is_long(md_op);
  assign stall_req = busy || (start && is_long(md_op));
  assign load      = is_div(md_op) ? CW'(DIV_CYCLES)
                                   : CW'(MULT_CYCLES);

  mdu_seq #(.CW(CW)) u_seq (
    .clk      (clk),
    .reset    (reset),
    .accept_i (accept),
    .load_i   (load),
    .busy_o   (busy),
    .done_o   (done)
  );

  // Arithmetic on the captured operands.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    sgn    = (op_q == OP_DIV);
    abs_a  = (sgn && a_q[31]) ? -a_q : a_q;
    abs_b  = (sgn && b_q[31]) ? -b_q : b_q;
    b_nz   = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_u    = abs_a / b_nz;
    r_u    = abs_a % b_nz;
    q_s    = (sgn && (a_q[31] ^ b_q[31])) ? -q_u : q_u;
    r_s    = (sgn && a_q[31]) ? -r_u : r_u;
  end

  // Operand capture, HI/LO update and misuse detection.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    ill_d = start && busy;
    if (accept) begin
      a_d  = rs_val;
      b_d  = rt_val;
      op_d = md_op;
    end
    if (done) begin
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_DIV, OP_DIVU: begin
          if (b_q != 32'd0) begin
            lo_d = q_s;
            hi_d = r_s;
          end
        end
`ifdef MDU_MADD_EN
        OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
        default: ;
      endcase
    end else if (start && !busy) begin
      if (md_op == OP_MTHI) hi_d = rs_val;
      if (md_op == OP_MTLO) lo_d = rs_val;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      ill_q <= ill_d;
    end
  end

  assign hi            = hi_q;
  assign lo            = lo_q;
  assign illegal_issue = ill_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed results.
// Covers MDU_MADD_EN builds as well as the default build.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        illegal_issue;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .md_op         (md_op),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .busy          (busy),
    .stall_req     (stall_req),
    .hi            (hi),
    .lo            (lo),
    .illegal_issue (illegal_issue)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle; report stall_req seen during it.
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic stl);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    stl = stall_req;
    tick();
    start  = 1'b0;
    md_op  = OP_NONE;
    rs_val = 32'hDEADBEEF;
    rt_val = 32'h0BADF00D;
  endtask

  // Count busy cycles, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  logic stl;
  int   n;
  int   ill_cnt;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = OP_NONE;
    rs_val = '0;
    rt_val = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ill", illegal_issue, 0);
    chk("rst_stall", stall_req, 0);

    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, stl);
    chk("mult_stall", stl, 1);
    wait_idle(n);
    chk("mult_cycles", n, 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, stl);
    wait_idle(n);
    chk("multu_cycles", n, 5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, stl);
    chk("div_stall", stl, 1);
    wait_idle(n);
    chk("div_cycles", n, 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(OP_MTHI, 32'h11, 32'd0, stl);
    chk("mthi_stall", stl, 0);
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h11);
    issue(OP_MTLO, 32'h22, 32'd0, stl);
    chk("mtlo_lo", lo, 32'h22);

    issue(OP_DIVU, 32'd5, 32'd0, stl);
    wait_idle(n);
    chk("dz_cycles", n, 10);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, stl);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    issue(OP_DIVU, 32'hFFFFFFFF, 32'd16, stl);
    wait_idle(n);
    chk("divu_lo", lo, 32'h0FFFFFFF);
    chk("divu_hi", hi, 32'h0000000F);

    issue(OP_NONE, 32'h5, 32'h6, stl);
    chk("nop_stall", stl, 0);
    chk("nop_busy", busy, 0);
    issue(4'd12, 32'h5, 32'h6, stl);
    chk("undef_busy", busy, 0);
    chk("undef_hi", hi, 32'h0000000F);

    issue(OP_MULT, 32'd3, 32'd4, stl);
    tick();
    issue(OP_MULT, 32'd100, 32'd100, stl);
    chk("ill_stall", stl, 1);
    ill_cnt = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (illegal_issue === 1'b1) ill_cnt++;
      n++;
      tick();
    end
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_cycles", n, 3);
    chk("ill_hi", hi, 32'h0);
    chk("ill_lo", lo, 32'd12);

    issue(OP_DIV, 32'd100, 32'd7, stl);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("abort_hi_late", hi, 0);
    chk("abort_lo_late", lo, 0);

    reset = 1'b1;
    issue(OP_MULT, 32'd7, 32'd7, stl);
    reset = 1'b0;
    chk("rst_prio_busy", busy, 0);
    tick();
    chk("rst_prio_busy2", busy, 0);

    issue(OP_MTHI, 32'h0, 32'd0, stl);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, stl);
    issue(OP_MADD, 32'd1, 32'd1, stl);
`ifdef MDU_MADD_EN
    chk("madd_stall", stl, 1);
    wait_idle(n);
    chk("madd_cycles", n, 5);
    chk("madd_hi", hi, 32'h1);
    chk("madd_lo", lo, 32'h0);
    issue(OP_MSUB, 32'd1, 32'd1, stl);
    wait_idle(n);
    chk("msub_hi", hi, 32'h0);
    chk("msub_lo", lo, 32'hFFFFFFFF);
`else
    chk("madd_stall", stl, 0);
    chk("madd_busy", busy, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("madd_hi", hi, 32'h0);
    chk("madd_lo", lo, 32'hFFFFFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
